// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core.
//   sw_state_t   : control FSM states
//   bcd_digit_t  : one BCD display digit
//   DIGIT_MAX    : highest value of a decimal digit
//   TENS_SEC_MAX : highest value of the tens-of-seconds digit
//   bcd_inc      : wrap-around increment of one BCD digit
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SW_IDLE,
    SW_RUN,
    SW_PAUSE
  } sw_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t DIGIT_MAX    = 4'd9;
  localparam bcd_digit_t TENS_SEC_MAX = 4'd5;

  function automatic bcd_digit_t bcd_inc(input bcd_digit_t d, input bcd_digit_t max);
    return (d == max) ? '0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Button inputs and display/status outputs of the stopwatch core.
//   btn_*      : raw active-high push-buttons (asynchronous to clk)
//   disp_d3..0 : BCD digits SS.hh towards the 7-segment decoders
//   running    : high in RUN
//   lap_frozen : high while the captured lap value is displayed
//   rollover   : one-cycle pulse after 59.99 wraps to 00.00
// master = environment side, slave = stopwatch core side.
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic       btn_start_stop;
  logic       btn_clear;
  logic       btn_lap;
  bcd_digit_t disp_d3;
  bcd_digit_t disp_d2;
  bcd_digit_t disp_d1;
  bcd_digit_t disp_d0;
  logic       running;
  logic       lap_frozen;
  logic       rollover;

  modport master (
    output btn_start_stop, btn_clear, btn_lap,
    input  disp_d3, disp_d2, disp_d1, disp_d0, running, lap_frozen, rollover
  );

  modport slave (
    input  btn_start_stop, btn_clear, btn_lap,
    output disp_d3, disp_d2, disp_d1, disp_d0, running, lap_frozen, rollover
  );

endinterface

// File: rtl/button_conditioner.sv
// Conditions one raw push-button: 2-FF synchroniser, debounce, and a
// one-cycle pulse on each accepted press (0->1 of the accepted level).
//   clk, rst : clock, asynchronous active-high reset
//   btn_raw  : raw button level
//   press    : registered one-cycle press pulse
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Counter runs only while the synchronised level disagrees with the
  // accepted level; any agreement restarts the hold interval.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
        press_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch control and time-keeping: conditions three buttons, runs the
// IDLE/RUN/PAUSE FSM, divides clk into a hundredth tick and keeps a BCD
// SS.hh count (00.00-59.99) with a lap-freeze display.
//   clk, reset : clock, asynchronous active-high reset
//   sw         : buttons in, BCD digits and status out (stopwatch_if.slave)
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 500000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  stopwatch_if.slave  sw
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  logic ss_p, clr_p, lap_p;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_ss (
    .clk     (clk),
    .rst     (reset),
    .btn_raw (sw.btn_start_stop),
    .press   (ss_p)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clr (
    .clk     (clk),
    .rst     (reset),
    .btn_raw (sw.btn_clear),
    .press   (clr_p)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
    .clk     (clk),
    .rst     (reset),
    .btn_raw (sw.btn_lap),
    .press   (lap_p)
  );

  sw_state_t     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  bcd_digit_t    cnt_q [4];
  bcd_digit_t    cnt_d [4];
  bcd_digit_t    lap_q [4];
  bcd_digit_t    lap_d [4];
  logic          frozen_q, frozen_d;
  logic          roll_q, roll_d;
  logic          running_q, running_d;
  logic          tick;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    lap_d    = lap_q;
    frozen_d = frozen_q;
    roll_d   = 1'b0;
    tick     = 1'b0;

    // Tick is keyed on the current state, so a tick coinciding with the
    // RUN->PAUSE transition still lands.
    if (state_q == SW_RUN) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    if (tick) begin
      cnt_d[0] = bcd_inc(cnt_q[0], DIGIT_MAX);
      if (cnt_q[0] == DIGIT_MAX) begin
        cnt_d[1] = bcd_inc(cnt_q[1], DIGIT_MAX);
        if (cnt_q[1] == DIGIT_MAX) begin
          cnt_d[2] = bcd_inc(cnt_q[2], DIGIT_MAX);
          if (cnt_q[2] == DIGIT_MAX) begin
            cnt_d[3] = bcd_inc(cnt_q[3], TENS_SEC_MAX);
            roll_d   = (cnt_q[3] == TENS_SEC_MAX);
          end
        end
      end
    end

    // Press priority clr > ss > lap; lower-priority pulses are dropped.
    case (state_q)
      SW_IDLE: begin
        if (ss_p) state_d = SW_RUN;
      end
      SW_RUN: begin
        if (ss_p) begin
          state_d = SW_PAUSE;
        end else if (lap_p) begin
          // Capture the pre-increment count of this cycle.
          if (!frozen_q) lap_d = cnt_q;
          frozen_d = ~frozen_q;
        end
      end
      SW_PAUSE: begin
        if (clr_p) begin
          state_d  = SW_IDLE;
          cnt_d    = '{default: '0};
          presc_d  = '0;
          frozen_d = 1'b0;
        end else if (ss_p) begin
          state_d = SW_RUN;
        end else if (lap_p) begin
          frozen_d = 1'b0;
        end
      end
      default: state_d = SW_IDLE;
    endcase

    running_d = (state_d == SW_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SW_IDLE;
      presc_q   <= '0;
      cnt_q     <= '{default: '0};
      lap_q     <= '{default: '0};
      frozen_q  <= 1'b0;
      roll_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      lap_q     <= lap_d;
      frozen_q  <= frozen_d;
      roll_q    <= roll_d;
      running_q <= running_d;
    end
  end

  assign sw.disp_d3    = frozen_q ? lap_q[3] : cnt_q[3];
  assign sw.disp_d2    = frozen_q ? lap_q[2] : cnt_q[2];
  assign sw.disp_d1    = frozen_q ? lap_q[1] : cnt_q[1];
  assign sw.disp_d0    = frozen_q ? lap_q[0] : cnt_q[0];
  assign sw.running    = running_q;
  assign sw.lap_frozen = frozen_q;
  assign sw.rollover   = roll_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core. The reference model keeps time as
// an integer count of hundredths and derives the digits arithmetically.
module tb_stopwatch_core;

  localparam int TD = 4;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stopwatch_if sw_if ();

  stopwatch_core #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw_if)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // state: 0 idle, 1 run, 2 pause
  int m_state, m_val, m_lap, m_presc;
  bit m_frozen, m_roll;
  bit r1 [3], r2 [3], acc [3], pul [3], raw [3], np [3];
  int hold [3];
  bit tk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = 0; m_val = 0; m_lap = 0; m_presc = 0;
      m_frozen = 0; m_roll = 0;
      for (int b = 0; b < 3; b++) begin
        r1[b] = 0; r2[b] = 0; acc[b] = 0; pul[b] = 0; hold[b] = 0;
      end
    end else begin
      raw[0] = sw_if.btn_start_stop;
      raw[1] = sw_if.btn_clear;
      raw[2] = sw_if.btn_lap;
      // A level is accepted after DB consecutive disagreeing samples.
      for (int b = 0; b < 3; b++) begin
        np[b] = 0;
        if (r2[b] != acc[b]) hold[b]++; else hold[b] = 0;
        if (hold[b] == DB) begin
          acc[b] = !acc[b];
          hold[b] = 0;
          np[b] = acc[b];
        end
        r2[b] = r1[b];
        r1[b] = raw[b];
      end
      tk = 0;
      if (m_state == 1) begin
        m_presc++;
        if (m_presc == TD) begin m_presc = 0; tk = 1; end
      end
      m_roll = tk && (m_val == 5999);
      case (m_state)
        0: if (pul[0]) m_state = 1;
        1: if (pul[0]) m_state = 2;
           else if (pul[2]) begin
             if (!m_frozen) m_lap = m_val;
             m_frozen = !m_frozen;
           end
        default: if (pul[1]) begin
             m_state = 0; m_val = 0; m_presc = 0; m_frozen = 0; tk = 0;
           end else if (pul[0]) m_state = 1;
           else if (pul[2]) m_frozen = 0;
      endcase
      if (tk) m_val = (m_val + 1) % 6000;
      for (int b = 0; b < 3; b++) pul[b] = np[b];
    end
  end

  function automatic int to_bcd(input int v);
    return ((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int disp_act();
    return {16'h0, sw_if.disp_d3, sw_if.disp_d2, sw_if.disp_d1, sw_if.disp_d0};
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("disp", disp_act(), to_bcd(m_frozen ? m_lap : m_val));
    chk("running", int'(sw_if.running), int'(m_state == 1));
    chk("lap_frozen", int'(sw_if.lap_frozen), int'(m_frozen));
    chk("rollover", int'(sw_if.rollover), int'(m_roll));
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit ss, input bit clr, input bit lap);
    sw_if.btn_start_stop = ss;
    sw_if.btn_clear      = clr;
    sw_if.btn_lap        = lap;
    cycles(DB + 4);
    sw_if.btn_start_stop = 0;
    sw_if.btn_clear      = 0;
    sw_if.btn_lap        = 0;
    cycles(DB + 4);
  endtask

  int i;

  initial begin
    reset = 1;
    sw_if.btn_start_stop = 0;
    sw_if.btn_clear      = 0;
    sw_if.btn_lap        = 0;
    cycles(3);
    reset = 0;
    chk("rst_disp", disp_act(), 0);
    chk("rst_running", int'(sw_if.running), 0);
    chk("rst_lap", int'(sw_if.lap_frozen), 0);

    // Short glitch must not start the watch.
    sw_if.btn_start_stop = 1;
    cycles(2);
    sw_if.btn_start_stop = 0;
    cycles(12);
    chk("glitch_running", int'(sw_if.running), 0);
    chk("glitch_disp", disp_act(), 0);

    // Held press: RUN seven sampled cycles later, then 10 ticks in 40 cycles.
    sw_if.btn_start_stop = 1;
    for (i = 0; i < 20 && !sw_if.running; i++) @(negedge clk);
    chk("ss_latency", i, 7);
    cycles(3);
    sw_if.btn_start_stop = 0;
    cycles(37);
    chk("ten_ticks", disp_act(), 16'h0010);

    // Lap freeze, hold for a while, release.
    press(0, 0, 1);
    chk("lap_on", int'(sw_if.lap_frozen), 1);
    cycles(32);
    press(0, 0, 1);
    chk("lap_off", int'(sw_if.lap_frozen), 0);

    // Freeze, pause, clear releases freeze and zeroes.
    press(0, 0, 1);
    press(1, 0, 0);
    chk("paused", int'(sw_if.running), 0);
    press(0, 1, 0);
    chk("clr_disp", disp_act(), 0);
    chk("clr_lap", int'(sw_if.lap_frozen), 0);

    // Clear and start/stop together in PAUSE: clear wins.
    press(1, 0, 0);
    cycles(20);
    press(1, 0, 0);
    press(1, 1, 0);
    chk("both_running", int'(sw_if.running), 0);
    chk("both_disp", disp_act(), 0);

    // Random button activity.
    for (int s = 0; s < 800; s++) begin
      sw_if.btn_start_stop = ($urandom_range(0, 3) == 0);
      sw_if.btn_clear      = ($urandom_range(0, 7) == 0);
      sw_if.btn_lap        = ($urandom_range(0, 3) == 0);
      cycles($urandom_range(1, 10));
    end
    sw_if.btn_start_stop = 0;
    sw_if.btn_clear      = 0;
    sw_if.btn_lap        = 0;
    cycles(12);

    // Full run to the 59.99 -> 00.00 wrap.
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
    press(1, 0, 0);
    for (i = 0; i < 25000 && !sw_if.rollover; i++) @(negedge clk);
    chk("rollover_seen", int'(sw_if.rollover), 1);
    chk("rollover_disp", disp_act(), 0);

    // Asynchronous reset in the middle of a run.
    for (i = 0; i < 2000 && disp_act() != 16'h0345; i++) @(negedge clk);
    chk("reach_0345", disp_act(), 16'h0345);
    #2 reset = 1;
    #1;
    chk("async_disp", disp_act(), 0);
    chk("async_running", int'(sw_if.running), 0);
    @(negedge clk) reset = 0;
    cycles(2);
    sw_if.btn_start_stop = 1;
    for (i = 0; i < 20 && !sw_if.running; i++) @(negedge clk);
    chk("restart_running", int'(sw_if.running), 1);
    chk("restart_zero", disp_act(), 0);
    cycles(3);
    chk("restart_pre_tick", disp_act(), 0);
    cycles(1);
    chk("restart_first_tick", disp_act(), 16'h0001);
    sw_if.btn_start_stop = 0;
    cycles(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Control and time-keeping stage that sits directly upstream of the 7-segment decoder/digit multiplexer. Conditions three raw push-buttons and runs an IDLE/RUN/PAUSE state machine. Keeps a four-digit BCD stopwatch value (SS.hh, 00.00–59.99) advanced by an internal 100 Hz tick, with a lap-freeze display feature. The four BCD digit outputs feed the decoders unchanged.

Parameters:
TICK_DIV, 500000, clk cycles per hundredth-second tick (50 MHz / 100 Hz); must be ≥2
DEBOUNCE_CYCLES, 1000000, cycles a synchronised button level must hold before it is accepted (20 ms); must be ≥2

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
btn_start_stop  in  1  raw button, active-high, asynchronous to clk
btn_clear  in  1  raw button, active-high, asynchronous to clk
btn_lap  in  1  raw button, active-high, asynchronous to clk
disp_d3  out  4  tens of seconds, BCD 0–5
disp_d2  out  4  seconds, BCD 0–9
disp_d1  out  4  tenths, BCD 0–9
disp_d0  out  4  hundredths, BCD 0–9
running  out  1  high in RUN
lap_frozen  out  1  high while the display shows the captured lap value
rollover  out  1  one-cycle pulse when 59.99 wraps to 00.00

Behaviour:
- Reset (async): state=IDLE; all counters, lap registers and prescaler = 0; running=0, lap_frozen=0, rollover=0; all disp_* = 0.
- Button conditioning (per button):
  - 2-FF synchroniser.
  - Debounce counter clears whenever the synchronised level equals the accepted level; otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the accepted level flips and the counter clears.
  - A one-cycle press pulse fires on a 0→1 flip of the accepted level.
  - If the raw input rises before edge t and stays high, the pulse is high in the cycle after edge t+DEBOUNCE_CYCLES+1.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse. Releases produce no pulse.
- FSM, driven by the press pulses ss, clr, lap:
  - IDLE: ss→RUN. clr and lap ignored.
  - RUN: ss→PAUSE. lap toggles the freeze: on freeze, lap registers capture the counter value present in that cycle, before any same-cycle increment. clr ignored.
  - PAUSE: ss→RUN. clr→IDLE, zeroing counters and prescaler and releasing the freeze. lap releases the freeze.
  - Priority within a cycle: clr > ss > lap. Lower-priority pulses in the same cycle are dropped.
- Tick generation:
  - The prescaler counts only in RUN and holds its value in PAUSE, so the partial hundredth is retained.
  - When prescaler == TICK_DIV-1, it wraps to 0 and a tick is applied that cycle.
  - A tick occurring in the cycle of the RUN→PAUSE transition is still applied.
- BCD cascade on tick, all registered and updated in the same clock:
  - d0 increments. d0 9→0 carries into d1; d1 9→0 carries into d2; d2 9→0 carries into d3; d3 5→0 at 59.99 wraps the value to 00.00.
  - rollover pulses in the cycle after the wrap edge.
  - No digit ever holds a non-BCD value.
- Outputs:
  - disp_dN = lap_frozen ? lap_dN : cnt_dN. This is a combinational mux of registers with no added latency.
  - Counting continues underneath while frozen.
  - running = (state==RUN), registered with the state.
- Reset asserted mid-count or mid-debounce aborts immediately. After release, the first accepted press requires a full debounce interval.

Decomposition:
- Package stopwatch_pkg:
  - state enum sw_state_t {SW_IDLE, SW_RUN, SW_PAUSE}
  - BCD limit constants DIGIT_MAX=9 and TENS_SEC_MAX=5
  - bcd_digit_t typedef, logic [3:0]
- Sub-module button_conditioner: synchroniser, debounce and rising-pulse logic, parameter DEBOUNCE_CYCLES. Instantiated three times.
- Prescaler, FSM and BCD cascade live in stopwatch_core.

Test Plan (TICK_DIV=4, DEBOUNCE_CYCLES=4 unless noted):
1. Reset, then a 2-cycle glitch on btn_start_stop → no pulse; running=0; disp=0.0.0.0.
2. Hold btn_start_stop high 10 cycles → running=1. After 40 further cycles (10 ticks), disp = 0.0.1.0.
3. Preload a run to 0.0.0.9, next tick → 0.0.1.0. From 5.9.9.9, next tick → 0.0.0.0 with a 1-cycle rollover.
4. RUN at 0.1.2.3, press lap → lap_frozen=1 and disp holds 0.1.2.3 for 8 ticks. Press lap again → disp jumps to 0.1.3.1.
5. Pause with prescaler=2, press clear → IDLE, disp=0.0.0.0, lap_frozen=0. Assert btn_clear and btn_start_stop together in PAUSE → IDLE (clr wins).
6. Assert reset mid-RUN at 0.3.4.5 → all outputs 0 asynchronously before the next clk edge. Release, press ss → count restarts from 0.0.0.0 after exactly 4 cycles to the first tick.
